// File: rtl/alu_pkg.sv
// Shared ALU definitions for the shift/rotate units.
//   ALU_WIDTH    : datapath width (power of two)
//   ALU_SHAMT_W  : shift/rotate amount width, log2(ALU_WIDTH)
//   ALU_SHAMT_MASK : mask selecting the used amount bits
//   rotl_state_t : controller state for the sequential left rotate
package alu_pkg;

  localparam int ALU_WIDTH   = 32;
  localparam int ALU_SHAMT_W = 5;
  localparam logic [ALU_WIDTH-1:0] ALU_SHAMT_MASK = ALU_WIDTH'(ALU_WIDTH - 1);

  typedef enum logic {
    IDLE,
    RUN
  } rotl_state_t;

endpackage

// File: rtl/rotate_left_seq_if.sv
// Handshake/data bundle for rotate_left_seq.
//   start  : request (master -> slave), sampled when not busy
//   A, B   : operand and rotate amount (master -> slave)
//   busy   : operation in progress (slave -> master)
//   done   : one-cycle result-valid pulse (slave -> master)
//   result : rotated data, held until the next done (slave -> master)
interface rotate_left_seq_if #(
  parameter int WIDTH = alu_pkg::ALU_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (output start, A, B, input busy, done, result);
  modport slave  (input start, A, B, output busy, done, result);
endinterface

// File: rtl/rotl_step.sv
// Combinational rotate-left of din by amt bit positions (amt in 0..WIDTH-1).
//   din  : data in
//   amt  : rotate amount
//   dout : din rotated left by amt
module rotl_step #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic [WIDTH-1:0]   din,
  input  logic [SHAMT_W-1:0] amt,
  output logic [WIDTH-1:0]   dout
);

  logic [2*WIDTH-1:0] dbl;

  // Shifting the doubled word makes the wrap-around bits fall into the
  // upper half, so amt=0 needs no special case.
  always_comb begin
    dbl  = {din, din} << amt;
    dout = dbl[2*WIDTH-1:WIDTH];
  end

endmodule

// File: rtl/rotate_left_seq.sv
// Multi-cycle left bit-rotation unit: result = A rotated left by B mod WIDTH.
// Start/busy/done handshake; default build shifts one bit per cycle.
// Optional macro ROTATE_LEFT_BARREL_EN: rotate by the full amount in one
// RUN cycle (latency 1 for every amount, handshake unchanged).
// Ports:
//   clock : rising-edge clock
//   clear : asynchronous active-low reset
//   bus   : rotate_left_seq_if.slave (start, A, B, busy, done, result)
module rotate_left_seq
  import alu_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int SHAMT_W = ALU_SHAMT_W
) (
  input  logic               clock,
  input  logic               clear,
  rotate_left_seq_if.slave   bus
);

  rotl_state_t        state;
  logic [WIDTH-1:0]   data;
  logic [WIDTH-1:0]   step_out;
  logic [WIDTH-1:0]   result_q;
  logic [SHAMT_W-1:0] cnt;
  logic [SHAMT_W-1:0] step_amt;
  logic               busy_q;
  logic               done_q;

  // Only the low SHAMT_W bits of B select the amount.
  logic unused_b_hi;
  assign unused_b_hi = ^bus.B[WIDTH-1:SHAMT_W];

`ifdef ROTATE_LEFT_BARREL_EN
  assign step_amt = cnt;
`else
  assign step_amt = SHAMT_W'(1);
`endif

  rotl_step #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_step (
    .din  (data),
    .amt  (step_amt),
    .dout (step_out)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state    <= IDLE;
      data     <= '0;
      cnt      <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            data   <= bus.A;
            cnt    <= bus.B[SHAMT_W-1:0];
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
`ifdef ROTATE_LEFT_BARREL_EN
          data     <= step_out;
          cnt      <= '0;
          result_q <= step_out;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state    <= IDLE;
`else
          if (cnt != '0) begin
            data <= step_out;
            cnt  <= cnt - SHAMT_W'(1);
          end else begin
            result_q <= data;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state    <= IDLE;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_rotate_left_seq.sv
// Self-checking bench for rotate_left_seq: directed cases plus a random
// sweep over all amounts 0..63, checked against a bit-index reference model.
module tb_rotate_left_seq;

  logic clock;
  logic clear;
  int   n_checks;
  int   n_pass;

  rotate_left_seq_if #(.WIDTH(32)) bus ();

  rotate_left_seq #(
    .WIDTH   (32),
    .SHAMT_W (5)
  ) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
  endtask

  // Bit i of a moves to position (i+n) mod 32.
  function automatic logic [31:0] model_rotl(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    int unsigned n;
    n = b % 32;
    for (int unsigned i = 0; i < 32; i++) r[(i + n) % 32] = a[i];
    return r;
  endfunction

  // Bit i of the result comes from position (i+k) mod 32.
  function automatic logic [31:0] model_rotr(input logic [31:0] a, input int unsigned k);
    logic [31:0] r;
    for (int unsigned i = 0; i < 32; i++) r[i] = a[(i + k) % 32];
    return r;
  endfunction

  function automatic int exp_lat(input logic [31:0] b);
`ifdef ROTATE_LEFT_BARREL_EN
    return 1;
`else
    return int'(b % 32) + 1;
`endif
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input bit immediate, input bit repulse,
                        output logic [31:0] res, output int lat,
                        output int busy_cyc, output bit held_ok);
    logic [31:0] prev;
    prev     = bus.result;
    held_ok  = 1'b1;
    busy_cyc = 0;
    lat      = -1;
    if (!immediate) @(negedge clock);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    @(posedge clock); #1;
    bus.start = 1'b0;
    bus.A     = $urandom;
    bus.B     = $urandom;
    if (bus.busy) busy_cyc++;
    for (int c = 1; c <= 100; c++) begin
      if (repulse && c == 1) begin
        @(negedge clock);
        bus.start = 1'b1;
        bus.A     = 32'hFFFF_FFFF;
        bus.B     = 32'd3;
      end
      @(posedge clock); #1;
      bus.start = 1'b0;
      if (bus.done) begin
        lat = c;
        break;
      end
      if (bus.busy) busy_cyc++;
      if (bus.result !== prev) held_ok = 1'b0;
    end
    res = bus.result;
  endtask

  logic [31:0] res;
  int          lat;
  int          bcyc;
  bit          held;
  int          done_seen;

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    clear     = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;

    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    @(negedge clock);
    clear = 1'b1;

    // Reset in the middle of an operation.
    @(negedge clock);
    bus.start = 1'b1;
    bus.A     = 32'h8000_0001;
    bus.B     = 32'd8;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    clear = 1'b0;
    #1;
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_done", {31'd0, bus.done}, 32'd0);
    check("midrst_result", bus.result, 32'd0);
    @(negedge clock);
    clear     = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clock); #1;
      if (bus.done) done_seen++;
    end
    check("midrst_no_done", done_seen, 32'd0);
    check("midrst_result_hold", bus.result, 32'd0);

    // Basic rotate.
    run_op(32'h8000_0001, 32'd1, 1'b0, 1'b0, res, lat, bcyc, held);
    check("basic_result", res, 32'h0000_0003);
    check("basic_lat", lat, exp_lat(32'd1));
    @(posedge clock); #1;
    check("basic_done_pulse", {31'd0, bus.done}, 32'd0);

    // Zero and wrapping amounts.
    run_op(32'h1234_5678, 32'd0, 1'b0, 1'b0, res, lat, bcyc, held);
    check("b0_result", res, 32'h1234_5678);
    check("b0_lat", lat, 32'd1);
    run_op(32'h1234_5678, 32'd32, 1'b0, 1'b0, res, lat, bcyc, held);
    check("b32_result", res, 32'h1234_5678);
    check("b32_lat", lat, 32'd1);
    run_op(32'h1234_5678, 32'd36, 1'b0, 1'b0, res, lat, bcyc, held);
    check("b36_result", res, 32'h2345_6781);
    check("b36_lat", lat, exp_lat(32'd36));

    // Maximum amount.
    run_op(32'hF000_0000, 32'd31, 1'b0, 1'b0, res, lat, bcyc, held);
    check("max_result", res, 32'h7800_0000);
    check("max_lat", lat, exp_lat(32'd31));
    check("max_busy_cycles", bcyc, lat);
    check("max_result_held", {31'd0, held}, 32'd1);

    // Start re-pulsed while busy is ignored.
    run_op(32'h1234_5678, 32'd10, 1'b0, 1'b1, res, lat, bcyc, held);
    check("repulse_result", res, model_rotl(32'h1234_5678, 32'd10));
    check("repulse_lat", lat, exp_lat(32'd10));
    repeat (3) begin
      @(posedge clock); #1;
      check("repulse_idle_busy", {31'd0, bus.busy}, 32'd0);
    end
    check("repulse_result_after", bus.result, model_rotl(32'h1234_5678, 32'd10));

    // Start in the done cycle is accepted; first result held meanwhile.
    run_op(32'h8000_0001, 32'd1, 1'b0, 1'b0, res, lat, bcyc, held);
    check("b2b_first_result", res, 32'h0000_0003);
    run_op(32'h0000_0001, 32'd4, 1'b1, 1'b0, res, lat, bcyc, held);
    check("b2b_second_result", res, 32'h0000_0010);
    check("b2b_second_lat", lat, exp_lat(32'd4));
    check("b2b_first_held", {31'd0, held}, 32'd1);

    // Equivalence sweep: rotl(A,B) == rotr(A, (32-B) mod 32).
    for (int unsigned b = 0; b < 64; b++) begin
      logic [31:0] a;
      a = $urandom;
      run_op(a, b, 1'b0, 1'b0, res, lat, bcyc, held);
      check($sformatf("sweep_rotr_b%0d", b), res, model_rotr(a, (32 - (b % 32)) % 32));
      check($sformatf("sweep_rotl_b%0d", b), res, model_rotl(a, b));
      check($sformatf("sweep_lat_b%0d", b), lat, exp_lat(b));
      check($sformatf("sweep_busy_b%0d", b), bcyc, exp_lat(b));
      @(posedge clock); #1;
      check($sformatf("sweep_done_pulse_b%0d", b), {31'd0, bus.done}, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
